jtag_ir_secure: RTL and testbench
=================================

Name: jtag_ir_secure

Overview:
- Parametrised JTAG instruction register, successor to the fixed 4-bit IR.
- Adds generic IR width, a legal-opcode mask, a privileged-opcode window gated by a security unlock, and strict shift-length checking.
- Sticky error status is reported through the IR capture value.
- Sits beside the TAP controller, consumes its 4-bit tap_state, and feeds IR and decode to the DR mux and the security/PUF logic.

Parameters:
- IR_WIDTH, 4, instruction register width (>=4).
- RESET_OPCODE, 1, opcode loaded on reset and in Test-Logic-Reset (IDCODE).
- BYPASS_OPCODE, all-ones (4'hF), substitute for illegal or denied opcodes.
- VALID_MASK, 16'h81DF, width 2**IR_WIDTH; bit i=1 means opcode i is implemented (0,1,2,3,4,6,7,8,15).
- PRIV_LO, 6, lowest privileged opcode (PUF_AUTH).
- PRIV_HI, 8, highest privileged opcode (SEC_CONFIG_DEC).
- STRICT_LEN, 1, 1 means reject UPDATE_IR unless exactly IR_WIDTH shifts occurred since CAPTURE_IR.

Ports:
- TCK  input  1  TAP clock; all state changes on rising edge.
- TRST  input  1  synchronous, active-high reset.
- TDI  input  1  serial data in.
- tap_state  input  4  TAP state, IEEE encoding (TLR=F, CAPTURE_IR=E, SHIFT_IR=A, UPDATE_IR=D).
- sec_unlock  input  1  level; 1 = privileged opcodes permitted.
- IR  output  IR_WIDTH  active instruction.
- IR_tdo  output  1  serial out = ir_shift[0], combinational.
- ir_upd  output  1  one-cycle pulse after IR is written by UPDATE_IR.
- ir_priv  output  1  IR lies within [PRIV_LO, PRIV_HI]; registered together with IR.
- len_err  output  1  sticky shift-length error.
- priv_err  output  1  sticky privileged-access-denied error.

Behaviour:
- Reset (TRST=1 at a TCK edge): IR=RESET_OPCODE, ir_shift=0, shift count=0, ir_upd=0, ir_priv=0, len_err=0, priv_err=0. TRST overrides everything, including mid-shift.
- Test-Logic-Reset (tap_state=F): same effect as reset. len_err and priv_err clear.
- CAPTURE_IR:
  - ir_shift <= {0-pad, priv_err, len_err, 2'b01}. LSBs are fixed at 01 per IEEE 1149.1.
  - Shift count <= 0.
  - Sticky flags clear on the same edge (read-to-clear). If a flag would be set on the same edge, set wins. This case cannot occur through legal TAP sequencing.
- SHIFT_IR:
  - ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
  - Count increments, saturating at IR_WIDTH+1. Count width is $clog2(IR_WIDTH+2).
- UPDATE_IR, evaluated in priority order:
  1. STRICT_LEN=1 and count != IR_WIDTH: IR unchanged, len_err<=1, no ir_upd.
  2. VALID_MASK[ir_shift]=0: IR<=BYPASS_OPCODE, ir_upd.
  3. ir_shift within [PRIV_LO, PRIV_HI] and sec_unlock=0: IR<=BYPASS_OPCODE, priv_err<=1, ir_upd.
  4. Otherwise: IR<=ir_shift, ir_upd.
- ir_upd is high for exactly the one cycle following the UPDATE_IR edge. It is 0 in all other states.
- ir_priv is computed from the written IR value and updates on the same edge as IR.
- All other states (pause, exit, DR path): ir_shift, count, IR and flags hold.
- sec_unlock is sampled only at UPDATE_IR. Dropping it afterwards does not change IR; re-entry is required.
- Flags accumulate across multiple UPDATE_IRs until the next CAPTURE_IR, TLR or TRST.

Test Plan:
- TRST=1 one cycle, then TLR -> IR=0001, ir_priv=0, len_err=0, priv_err=0. CAPTURE_IR -> IR_tdo sequence 1,0,0,0.
- Capture, shift 4 bits of 0010 LSB-first, update -> IR=0010, ir_upd high one cycle, ir_priv=0.
- Shift 0101 (opcode 5, not in VALID_MASK), update -> IR=1111. Shift 1001 (opcode 9), update -> IR=1111.
- sec_unlock=0, shift 0110, update -> IR=1111, priv_err=1. Next CAPTURE_IR shifts out 1,0,0,1 and clears priv_err. With sec_unlock=1, repeat -> IR=0110, ir_priv=1.
- Shift only 3 bits (or 6 bits), update -> IR unchanged, len_err=1, no ir_upd. Next capture shifts out 1,0,1,0.
- IR_WIDTH=6 variant: shift 6-bit 000111 -> IR=000111. Assert TRST mid-SHIFT_IR -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/jtag_ir_secure.sv
// Parametrised JTAG instruction register with legal-opcode filtering,
// a security-gated privileged opcode window and strict shift-length checking.
// Sticky error flags are reported through the CAPTURE_IR value and clear on read.
module jtag_ir_secure #(
  parameter int                     IR_WIDTH      = 4,
  parameter logic [IR_WIDTH-1:0]    RESET_OPCODE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]    BYPASS_OPCODE = '1,
  parameter logic [2**IR_WIDTH-1:0] VALID_MASK    = (2**IR_WIDTH)'('h81DF),
  parameter int                     PRIV_LO       = 6,
  parameter int                     PRIV_HI       = 8,
  parameter bit                     STRICT_LEN    = 1'b1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic [3:0]          tap_state,
  input  logic                sec_unlock,
  output logic [IR_WIDTH-1:0] IR,
  output logic                IR_tdo,
  output logic                ir_upd,
  output logic                ir_priv,
  output logic                len_err,
  output logic                priv_err
);

  localparam int CW = $clog2(IR_WIDTH + 2);

  localparam logic [CW-1:0] CNT_FULL = CW'(IR_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(IR_WIDTH + 1);

  localparam logic [IR_WIDTH-1:0] PRIV_LO_V = IR_WIDTH'(PRIV_LO);
  localparam logic [IR_WIDTH-1:0] PRIV_HI_V = IR_WIDTH'(PRIV_HI);

  localparam logic [3:0] TS_TLR        = 4'hF;
  localparam logic [3:0] TS_CAPTURE_IR = 4'hE;
  localparam logic [3:0] TS_SHIFT_IR   = 4'hA;
  localparam logic [3:0] TS_UPDATE_IR  = 4'hD;

  logic [IR_WIDTH-1:0] ir_shift;
  logic [CW-1:0]       shift_cnt;

  logic [IR_WIDTH-1:0] shift_nxt;
  logic [CW-1:0]       cnt_nxt;
  logic [IR_WIDTH-1:0] ir_nxt;
  logic                upd_nxt;
  logic                len_nxt;
  logic                priv_nxt;
  logic [IR_WIDTH-1:0] capture_val;

  function automatic logic in_priv(input logic [IR_WIDTH-1:0] op);
    return (op >= PRIV_LO_V) && (op <= PRIV_HI_V);
  endfunction

  assign IR_tdo = ir_shift[0];

  // Capture word: error flags above the mandatory 2'b01 LSBs, zero padded.
  always_comb begin
    capture_val      = '0;
    capture_val[3:0] = {priv_err, len_err, 2'b01};
  end

  // Next-state for the shift register, counter, IR and sticky flags.
  always_comb begin
    shift_nxt = ir_shift;
    cnt_nxt   = shift_cnt;
    ir_nxt    = IR;
    upd_nxt   = 1'b0;
    len_nxt   = len_err;
    priv_nxt  = priv_err;
    case (tap_state)
      TS_CAPTURE_IR: begin
        // Flags are only ever set in UPDATE_IR, so clearing here never races a set.
        shift_nxt = capture_val;
        cnt_nxt   = '0;
        len_nxt   = 1'b0;
        priv_nxt  = 1'b0;
      end
      TS_SHIFT_IR: begin
        shift_nxt = {TDI, ir_shift[IR_WIDTH-1:1]};
        if (shift_cnt != CNT_SAT) cnt_nxt = shift_cnt + CW'(1);
      end
      TS_UPDATE_IR: begin
        if (STRICT_LEN && (shift_cnt != CNT_FULL)) begin
          len_nxt = 1'b1;
        end else if (!VALID_MASK[ir_shift]) begin
          ir_nxt  = BYPASS_OPCODE;
          upd_nxt = 1'b1;
        end else if (in_priv(ir_shift) && !sec_unlock) begin
          ir_nxt   = BYPASS_OPCODE;
          priv_nxt = 1'b1;
          upd_nxt  = 1'b1;
        end else begin
          ir_nxt  = ir_shift;
          upd_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State register; TRST and Test-Logic-Reset both force the reset image.
  always_ff @(posedge TCK) begin
    if (TRST || (tap_state == TS_TLR)) begin
      IR        <= RESET_OPCODE;
      ir_shift  <= '0;
      shift_cnt <= '0;
      ir_upd    <= 1'b0;
      ir_priv   <= 1'b0;
      len_err   <= 1'b0;
      priv_err  <= 1'b0;
    end else begin
      IR        <= ir_nxt;
      ir_shift  <= shift_nxt;
      shift_cnt <= cnt_nxt;
      ir_upd    <= upd_nxt;
      ir_priv   <= in_priv(ir_nxt);
      len_err   <= len_nxt;
      priv_err  <= priv_nxt;
    end
  end

endmodule

// File: tb/tb_jtag_ir_secure.sv
// Self-checking bench: a 4-bit and a 6-bit instance share one TAP stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_jtag_ir_secure;

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       TDI = 1'b0;
  logic [3:0] tap_state = 4'hF;
  logic       sec_unlock = 1'b0;

  logic [3:0] ir4;
  logic       tdo4, upd4, priv4, len4, perr4;
  logic [5:0] ir6;
  logic       tdo6, upd6, priv6, len6, perr6;

  int errs = 0;
  int checks = 0;

  jtag_ir_secure u4 (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .sec_unlock(sec_unlock),
    .IR(ir4), .IR_tdo(tdo4), .ir_upd(upd4), .ir_priv(priv4), .len_err(len4), .priv_err(perr4)
  );

  jtag_ir_secure #(.IR_WIDTH(6)) u6 (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .sec_unlock(sec_unlock),
    .IR(ir6), .IR_tdo(tdo6), .ir_upd(upd6), .ir_priv(priv6), .len_err(len6), .priv_err(perr6)
  );

  always #5 TCK = ~TCK;

  // Reference model, index 0 = 4-bit instance, 1 = 6-bit instance.
  int m_ir[2], m_sh[2], m_cnt[2], m_upd[2], m_len[2], m_pe[2];
  logic [63:0] vmask = 64'h81DF;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic trst, input logic [3:0] st,
                            input logic tdi, input logic unl);
    int w;
    w = (k == 1) ? 6 : 4;
    if (trst || st == 4'hF) begin
      m_ir[k] = 1; m_sh[k] = 0; m_cnt[k] = 0; m_upd[k] = 0; m_len[k] = 0; m_pe[k] = 0;
    end else begin
      m_upd[k] = 0;
      if (st == 4'hE) begin
        m_sh[k] = 1 + 4 * m_len[k] + 8 * m_pe[k];
        m_cnt[k] = 0; m_len[k] = 0; m_pe[k] = 0;
      end else if (st == 4'hA) begin
        m_sh[k] = (m_sh[k] >> 1) + (tdi ? (1 << (w - 1)) : 0);
        if (m_cnt[k] < w + 1) m_cnt[k]++;
      end else if (st == 4'hD) begin
        if (m_cnt[k] != w) begin
          m_len[k] = 1;
        end else if (!vmask[m_sh[k]]) begin
          m_ir[k] = (1 << w) - 1; m_upd[k] = 1;
        end else if (m_sh[k] >= 6 && m_sh[k] <= 8 && !unl) begin
          m_ir[k] = (1 << w) - 1; m_pe[k] = 1; m_upd[k] = 1;
        end else begin
          m_ir[k] = m_sh[k]; m_upd[k] = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("ir4", ir4, m_ir[0]);
    chk("tdo4", tdo4, m_sh[0] % 2);
    chk("upd4", upd4, m_upd[0]);
    chk("priv4", priv4, (m_ir[0] >= 6 && m_ir[0] <= 8) ? 1 : 0);
    chk("len4", len4, m_len[0]);
    chk("perr4", perr4, m_pe[0]);
    chk("ir6", ir6, m_ir[1]);
    chk("tdo6", tdo6, m_sh[1] % 2);
    chk("upd6", upd6, m_upd[1]);
    chk("priv6", priv6, (m_ir[1] >= 6 && m_ir[1] <= 8) ? 1 : 0);
    chk("len6", len6, m_len[1]);
    chk("perr6", perr6, m_pe[1]);
  endtask

  task automatic tick(input logic trst, input logic [3:0] st, input logic tdi, input logic unl);
    TRST = trst; tap_state = st; TDI = tdi; sec_unlock = unl;
    @(posedge TCK);
    model_step(0, trst, st, tdi, unl);
    model_step(1, trst, st, tdi, unl);
    #1;
    compare_all();
  endtask

  task automatic shift_bits(input logic [7:0] val, input int n);
    logic [7:0] v;
    v = val;
    for (int i = 0; i < n; i++) tick(1'b0, 4'hA, v[i], 1'b0);
  endtask

  // Capture, shift n bits, update with the given unlock level, then idle.
  task automatic load(input logic [7:0] val, input int n, input logic unl);
    tick(1'b0, 4'hE, 1'b0, 1'b0);
    shift_bits(val, n);
    tick(1'b0, 4'hB, 1'b0, 1'b0);
    tick(1'b0, 4'hD, 1'b0, unl);
    tick(1'b0, 4'hC, 1'b0, 1'b0);
  endtask

  initial begin
    tick(1'b1, 4'hC, 1'b0, 1'b0);
    tick(1'b0, 4'hF, 1'b0, 1'b0);
    chk("plan_reset_ir", ir4, 1);
    tick(1'b0, 4'hE, 1'b0, 1'b0);
    chk("plan_capture_tdo0", tdo4, 1);
    shift_bits(8'h00, 4);
    tick(1'b0, 4'hD, 1'b0, 1'b0);
    tick(1'b0, 4'hC, 1'b0, 1'b0);

    load(8'h02, 4, 1'b0);
    chk("plan_ir_0010", ir4, 2);
    load(8'h05, 4, 1'b1);
    chk("plan_ir_op5_bypass", ir4, 15);
    load(8'h02, 4, 1'b0);
    load(8'h09, 4, 1'b1);
    chk("plan_ir_op9_bypass", ir4, 15);
    load(8'h06, 4, 1'b0);
    chk("plan_priv_denied", perr4, 1);
    load(8'h06, 4, 1'b1);
    chk("plan_ir_priv_ok", ir4, 6);
    chk("plan_irpriv_set", priv4, 1);
    load(8'h02, 3, 1'b0);
    chk("plan_len_err", len4, 1);
    chk("plan_ir_hold", ir4, 6);
    load(8'h07, 6, 1'b1);
    chk("plan_ir6_000111", ir6, 7);
    tick(1'b0, 4'hE, 1'b0, 1'b0);
    shift_bits(8'h15, 3);
    tick(1'b1, 4'hA, 1'b1, 1'b0);
    chk("plan_trst_midshift", ir6, 1);

    for (int it = 0; it < 400; it++) begin
      int n;
      int pick;
      logic [7:0] v;
      pick = $urandom_range(0, 19);
      if (pick == 0) begin
        tick(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      end else if (pick == 1) begin
        tick(1'b0, 4'hF, 1'b0, 1'b0);
      end else if (pick == 2) begin
        tick(1'b0, 4'($urandom_range(2, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (pick == 3) begin
        tick(1'b0, 4'hD, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 6))
          0, 1, 2: n = 4;
          3, 4:    n = 6;
          5:       n = 3;
          default: n = 7;
        endcase
        v = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) v = 8'($urandom_range(5, 9));
        load(v, n, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
